// File: rtl/rca_msb_power_scheduler.sv
// Power-gating sequencer for the MSB half of RCA_32 with a valid/ready request front end.
// Narrow ops always pass; wide ops power the MSB domain up on demand and keep it alive.
module rca_msb_power_scheduler #(
  parameter int unsigned PWR_UP_CYC   = 4,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned OP_LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wide,
  output logic        req_ready,
  input  logic        force_off,
  output logic        op_issue,
  output logic        op_wide,
  output logic        iso_en,
  output logic        ret_en,
  output logic        pse,
  output logic        msb_on,
  output logic [15:0] pwr_up_cnt
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    UP_WAIT = 3'd1,
    UP_RES  = 3'd2,
    ON      = 3'd3,
    DN_ISO  = 3'd4,
    DN_RET  = 3'd5
  } state_t;

  localparam logic [7:0]  WAIT_LAST  = 8'(PWR_UP_CYC - 1);
  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_TIMEOUT);
  localparam logic [7:0]  DRAIN_LD   = 8'(OP_LAT);

  state_t      state_r, state_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s;
  logic [15:0] idle_cnt_r, idle_cnt_s;
  logic [7:0]  drain_cnt_r, drain_cnt_s;
  logic [15:0] pwr_up_cnt_r, pwr_up_cnt_s;
  logic        op_issue_r, op_issue_s;
  logic        op_wide_r, op_wide_s;
  logic        iso_r, iso_s;
  logic        ret_r, ret_s;
  logic        pse_r, pse_s;
  logic        msb_on_r, msb_on_s;
  logic        ready_s;
  logic        wide_accept_s;

  // Request handshake: wide ops only while the domain is fully on and not being forced down.
  always_comb begin
    if (rst) begin
      ready_s = 1'b0;
    end else if (!req_wide) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (state_r == ON) && !force_off;
    end
    wide_accept_s = req_valid && req_wide && ready_s;
  end

  assign req_ready = ready_s;

  // Next-state and counter logic.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = 8'd0;
    idle_cnt_s = 16'd0;
    op_issue_s = req_valid && ready_s;
    op_wide_s  = wide_accept_s;
    // The drain counter guards isolation until the last wide op has left the adder.
    if (wide_accept_s) begin
      drain_cnt_s = DRAIN_LD;
    end else if (drain_cnt_r != 8'd0) begin
      drain_cnt_s = drain_cnt_r - 8'd1;
    end else begin
      drain_cnt_s = 8'd0;
    end
    case (state_r)
      OFF: begin
        if (req_valid && req_wide && !force_off) begin
          state_s = UP_WAIT;
        end else begin
          state_s = OFF;
        end
      end
      UP_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s = UP_RES;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      UP_RES: state_s = ON;
      ON: begin
        if (wide_accept_s) begin
          idle_cnt_s = 16'd0;
          state_s    = ON;
        end else begin
          idle_cnt_s = idle_cnt_r + 16'd1;
          if ((idle_cnt_s >= IDLE_LIMIT) || (force_off && (drain_cnt_r == 8'd0))) begin
            state_s = DN_ISO;
          end else begin
            state_s = ON;
          end
        end
      end
      DN_ISO:  state_s = DN_RET;
      DN_RET:  state_s = OFF;
      default: state_s = OFF;
    endcase
  end

  // Power-control outputs decoded from the upcoming state so they register with it.
  always_comb begin
    iso_s    = 1'b1;
    ret_s    = 1'b1;
    pse_s    = 1'b0;
    msb_on_s = 1'b0;
    case (state_s)
      OFF:     begin iso_s = 1'b1; ret_s = 1'b1; pse_s = 1'b0; end
      UP_WAIT: begin iso_s = 1'b1; ret_s = 1'b1; pse_s = 1'b1; end
      UP_RES:  begin iso_s = 1'b1; ret_s = 1'b0; pse_s = 1'b1; end
      ON:      begin iso_s = 1'b0; ret_s = 1'b0; pse_s = 1'b1; msb_on_s = 1'b1; end
      DN_ISO:  begin iso_s = 1'b1; ret_s = 1'b0; pse_s = 1'b1; end
      DN_RET:  begin iso_s = 1'b1; ret_s = 1'b1; pse_s = 1'b1; end
      default: begin iso_s = 1'b1; ret_s = 1'b1; pse_s = 1'b0; end
    endcase
    if ((state_r == OFF) && (state_s == UP_WAIT) && (pwr_up_cnt_r != 16'hFFFF)) begin
      pwr_up_cnt_s = pwr_up_cnt_r + 16'd1;
    end else begin
      pwr_up_cnt_s = pwr_up_cnt_r;
    end
  end

  // State, counters and all outputs register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= OFF;
      wait_cnt_r   <= 8'd0;
      idle_cnt_r   <= 16'd0;
      drain_cnt_r  <= 8'd0;
      pwr_up_cnt_r <= 16'd0;
      op_issue_r   <= 1'b0;
      op_wide_r    <= 1'b0;
      iso_r        <= 1'b1;
      ret_r        <= 1'b1;
      pse_r        <= 1'b0;
      msb_on_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_cnt_r   <= wait_cnt_s;
      idle_cnt_r   <= idle_cnt_s;
      drain_cnt_r  <= drain_cnt_s;
      pwr_up_cnt_r <= pwr_up_cnt_s;
      op_issue_r   <= op_issue_s;
      op_wide_r    <= op_wide_s;
      iso_r        <= iso_s;
      ret_r        <= ret_s;
      pse_r        <= pse_s;
      msb_on_r     <= msb_on_s;
    end
  end

  assign op_issue   = op_issue_r;
  assign op_wide    = op_wide_r;
  assign iso_en     = iso_r;
  assign ret_en     = ret_r;
  assign pse        = pse_r;
  assign msb_on     = msb_on_r;
  assign pwr_up_cnt = pwr_up_cnt_r;

endmodule

// File: tb/tb_rca_msb_power_scheduler.sv
// Directed bench for rca_msb_power_scheduler: cycle model compared every cycle,
// plus literal expectations taken from hand-worked timelines.
module tb_rca_msb_power_scheduler;

  localparam int PWR_UP_CYC   = 4;
  localparam int IDLE_TIMEOUT = 16;
  localparam int OP_LAT       = 2;

  localparam int P_OFF = 0, P_UPW = 1, P_UPR = 2, P_ON = 3, P_DNI = 4, P_DNR = 5;
  // (iso, ret, pse) per phase, bit index = phase number
  localparam logic [5:0] ISO_T = 6'b110111;
  localparam logic [5:0] RET_T = 6'b100011;
  localparam logic [5:0] PSE_T = 6'b111110;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wide;
  logic        req_ready;
  logic        force_off;
  logic        op_issue;
  logic        op_wide;
  logic        iso_en;
  logic        ret_en;
  logic        pse;
  logic        msb_on;
  logic [15:0] pwr_up_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  rca_msb_power_scheduler #(
    .PWR_UP_CYC  (PWR_UP_CYC),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .OP_LAT      (OP_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wide  (req_wide),
    .req_ready (req_ready),
    .force_off (force_off),
    .op_issue  (op_issue),
    .op_wide   (op_wide),
    .iso_en    (iso_en),
    .ret_en    (ret_en),
    .pse       (pse),
    .msb_on    (msb_on),
    .pwr_up_cnt(pwr_up_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ph;     // current power phase
    int in_ph;  // cycles already spent in UP_WAIT
    int idle;   // ON cycles since last wide accept
    int since;  // cycles since the last wide op appeared on op_issue
    int ups;    // power-up sequences started
    bit iss;
    bit wid;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mstep(mdl_t c, bit r, bit v, bit w, bit f);
    mdl_t n;
    bit rdy, acc, wacc;
    n = c;
    if (r) begin
      n.ph = P_OFF; n.in_ph = 0; n.idle = 0; n.since = 1000; n.ups = 0;
      n.iss = 1'b0; n.wid = 1'b0;
      return n;
    end
    rdy   = !w || (c.ph == P_ON && !f);
    acc   = v && rdy;
    wacc  = acc && w;
    n.iss = acc;
    n.wid = wacc;
    n.since = wacc ? 0 : ((c.since < 1000) ? c.since + 1 : 1000);
    n.in_ph = 0;
    n.idle  = 0;
    case (c.ph)
      P_OFF: if (v && w && !f) begin
        n.ph  = P_UPW;
        n.ups = (c.ups < 65535) ? c.ups + 1 : 65535;
      end
      P_UPW: begin
        if (c.in_ph + 1 == PWR_UP_CYC) n.ph = P_UPR;
        else n.in_ph = c.in_ph + 1;
      end
      P_UPR: n.ph = P_ON;
      P_ON: begin
        if (!wacc) begin
          n.idle = c.idle + 1;
          if (n.idle == IDLE_TIMEOUT || (f && c.since >= OP_LAT)) n.ph = P_DNI;
        end
      end
      P_DNI: n.ph = P_DNR;
      default: n.ph = P_OFF;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= mstep(m, rst, req_valid, req_wide, force_off);

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("m_ready", req_ready, !rst && (!req_wide || (m.ph == P_ON && !force_off)));
      chk1("m_op_issue", op_issue, m.iss);
      chk1("m_op_wide", op_wide, m.wid);
      chk1("m_iso", iso_en, ISO_T[m.ph]);
      chk1("m_ret", ret_en, RET_T[m.ph]);
      chk1("m_pse", pse, PSE_T[m.ph]);
      chk1("m_msb_on", msb_on, m.ph == P_ON);
      chk16("m_pwr_up_cnt", pwr_up_cnt, 16'(m.ups));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_pwr(input string nm, input logic [2:0] exp);
    total++;
    if ({iso_en, ret_en, pse} !== exp) begin
      bad++;
      $display("FAIL %s: iso/ret/pse got %b want %b at %0t", nm, {iso_en, ret_en, pse}, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wide = 1'b0; force_off = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    chk_en = 1'b1;
    // reset state
    mid();
    chk_pwr("rst_pwr", 3'b110);
    chk1("rst_msb_on", msb_on, 1'b0);
    chk1("rst_op_issue", op_issue, 1'b0);
    chk16("rst_cnt", pwr_up_cnt, 16'd0);
    // narrow request at cycle 2
    next_cycle();
    next_cycle();
    req_valid = 1'b1; req_wide = 1'b0;
    mid();
    chk1("nar_ready", req_ready, 1'b1);
    next_cycle();
    req_valid = 1'b0;
    mid();
    chk1("nar_issue", op_issue, 1'b1);
    chk1("nar_wide", op_wide, 1'b0);
    chk_pwr("nar_pwr", 3'b110);

    // wide request from OFF at relative cycle 0
    next_cycle();
    req_valid = 1'b1; req_wide = 1'b1;
    mid();
    chk1("w0_ready", req_ready, 1'b0);
    for (int c = 1; c <= 43; c++) begin
      next_cycle();
      case (c)
        7:  req_valid = 1'b0;
        23: begin req_valid = 1'b1; req_wide = 1'b1; end
        32: begin req_valid = 1'b1; req_wide = 1'b0; force_off = 1'b1; end
        33: req_wide = 1'b1;
        38: force_off = 1'b0;
        40: rst = 1'b1;
        41: begin rst = 1'b0; req_valid = 1'b0; req_wide = 1'b0; end
        default: ;
      endcase
      mid();
      case (c)
        1, 2, 3, 4: chk_pwr("upw_pwr", 3'b111);
        5: chk_pwr("upres_pwr", 3'b101);
        6: begin
          chk_pwr("on_pwr", 3'b001);
          chk1("on_msb", msb_on, 1'b1);
          chk1("on_ready", req_ready, 1'b1);
        end
        7: begin
          chk1("w_issue", op_issue, 1'b1);
          chk1("w_wide", op_wide, 1'b1);
          chk16("w_cnt1", pwr_up_cnt, 16'd1);
        end
        22: chk1("idle_still_on", msb_on, 1'b1);
        23: chk_pwr("idle_dniso", 3'b101);
        24: chk_pwr("idle_dnret", 3'b111);
        25: chk_pwr("idle_off", 3'b110);
        26: begin
          chk_pwr("re_upw", 3'b111);
          chk16("re_cnt2", pwr_up_cnt, 16'd2);
        end
        31: chk1("re_ready", req_ready, 1'b1);
        32: begin
          chk1("re_issue", op_issue, 1'b1);
          chk1("re_wide", op_wide, 1'b1);
        end
        33: begin
          chk1("force_wide_ready", req_ready, 1'b0);
          chk1("force_nar_issue", op_issue, 1'b1);
          chk1("force_nar_wide", op_wide, 1'b0);
        end
        34: chk1("drain_on", msb_on, 1'b1);
        35: begin
          chk_pwr("force_dniso", 3'b101);
          chk1("force_msb", msb_on, 1'b0);
        end
        38: begin
          chk_pwr("force_hold_off", 3'b110);
          chk1("force_hold_ready", req_ready, 1'b0);
        end
        39: begin
          chk_pwr("rel_upw", 3'b111);
          chk16("rel_cnt3", pwr_up_cnt, 16'd3);
        end
        41: begin
          chk_pwr("midrst_pwr", 3'b110);
          chk1("midrst_msb", msb_on, 1'b0);
          chk16("midrst_cnt", pwr_up_cnt, 16'd0);
          chk1("midrst_issue", op_issue, 1'b0);
        end
        default: ;
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_msb_power_scheduler.md
Name: rca_msb_power_scheduler

Overview:
- Sequences power gating of the MSB half of RCA_32, and admits add requests to the adder through a valid/ready handshake.
- Narrow (16-bit) ops are always served by the always-on LSB half. Wide (32-bit) ops power the MSB domain up on demand.
- The MSB domain powers down after an idle timeout or on a force request.
- Drives iso_en / ret_en / pse of the MSB domain and supersedes the simple flag-driven power control.

Parameters:
- PWR_UP_CYC, 4: cycles pse is held before retention restore (rail settle); legal range 1..255.
- IDLE_TIMEOUT, 16: consecutive ON cycles without a wide accept before auto power-down; must be ≥ OP_LAT; legal range 1..65535.
- OP_LAT, 2: adder latency in cycles; the domain must not be isolated within OP_LAT cycles after a wide issue.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- req_valid, input, 1: request present.
- req_wide, input, 1: request needs MSB half; qualified by req_valid.
- req_ready, output, 1: request accepted this cycle when req_valid & req_ready.
- force_off, input, 1: level; power MSB domain down as soon as it is safe.
- op_issue, output, 1: one-cycle strobe to the datapath, registered, in the cycle after accept.
- op_wide, output, 1: width of the issued op; valid with op_issue.
- iso_en, output, 1: MSB output isolation clamp, 1 = clamped.
- ret_en, output, 1: MSB retention save/hold, 1 = retaining.
- pse, output, 1: MSB power switch enable, 1 = powered.
- msb_on, output, 1: state == ON.
- pwr_up_cnt, output, 16: number of power-up sequences started; saturates at 16'hFFFF.

Behaviour:
- All outputs are flop outputs, updated together with the state register. No combinational paths to iso_en, ret_en or pse.
- req_ready is combinational: 1 if !req_wide; if req_wide, 1 only when state == ON && !force_off.
- Narrow requests are accepted in every state except during reset.
- States, with outputs given as (iso, ret, pse):
  - OFF (1,1,0): reset state. A pending wide request (req_valid & req_wide) moves to UP_WAIT.
  - UP_WAIT (1,1,1): held for exactly PWR_UP_CYC cycles, then moves to UP_RES. pwr_up_cnt increments on entry.
  - UP_RES (1,0,1): one cycle, then moves to ON.
  - ON (0,0,1):
    - Idle counter clears on every wide accept and increments on every other ON cycle.
    - Moves to DN_ISO when the idle count reaches IDLE_TIMEOUT.
    - Also moves to DN_ISO when force_off = 1 and at least OP_LAT cycles have elapsed since the last wide issue (drain counter).
  - DN_ISO (1,0,1): one cycle, then moves to DN_RET.
  - DN_RET (1,1,1): one cycle, then moves to OFF.
- Power-down sequences are never aborted. A wide request arriving in DN_ISO/DN_RET waits: OFF → UP_WAIT on the next cycle.
- force_off held in OFF blocks power-up. Wide requests stall with req_ready = 0; narrow requests proceed.
- Simultaneous events:
  - A wide accept and a timeout in the same cycle: the accept wins and the idle counter clears.
  - force_off together with a wide request: no accept; shutdown proceeds once the drain condition is met.
- Outputs after reset (state OFF): op_issue = 0, op_wide = 0, iso_en = 1, ret_en = 1, pse = 0, msb_on = 0, pwr_up_cnt = 0. All counters clear.
- A reset asserted mid-sequence returns to OFF in the next cycle. No in-flight issue is reported after reset.
- Requesters must hold req_valid and req_wide stable until accepted.

Test Plan:
- Reset, then narrow request at cycle 2 → req_ready = 1 at cycle 2; op_issue = 1, op_wide = 0 at cycle 3; iso/ret/pse stay 1/1/0.
- Wide request at cycle 0 from OFF → pse = 1 for cycles 1–4; ret_en = 0 at cycle 5; iso_en = 0 and msb_on = 1 at cycle 6; accept at cycle 6; op_issue with op_wide = 1 at cycle 7; pwr_up_cnt = 1.
- After the cycle-6 wide accept, no further traffic → ON through cycle 22; DN_ISO at cycle 23 (1,0,1); DN_RET at cycle 24 (1,1,1); OFF at cycle 25 (1,1,0).
- Wide accept at cycle T, force_off raised at T+1 → DN_ISO not before T+2 (OP_LAT = 2); wide requests during force_off see req_ready = 0; narrow requests still issue.
- Wide request asserted during DN_ISO → DN_RET, then OFF, then UP_WAIT; pwr_up_cnt increments to 2; accept after the full PWR_UP_CYC + 2 cycle sequence.
- Reset asserted during UP_WAIT cycle 2 → next cycle iso/ret/pse = 1/1/0, msb_on = 0, pwr_up_cnt = 0, no op_issue.
